adc_serial_emu: RTL and testbench

- Clocked, parametrised emulator of a dual-output, simultaneous-sampling SAR ADC serial port (AD7265-class), used on validation benches and loop-back builds.
- It oversamples the ADC pins (adc_sclk, ncs) on the system clock, snapshots per-channel data when ncs falls, and shifts a configurable frame out on two data lines.
- Adds explicit output-enables, frame counting, truncation/address error flags, and differential coding over the simple pin model.

---
 rtl/adc_emu_pkg.sv | 23 ++
 rtl/adc_emu_edge_sync.sv | 35 +++
 rtl/adc_serial_emu.sv | 146 ++++++++++++++
 tb/tb_adc_serial_emu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared state encoding, frame sizing and frame assembly for adc_serial_emu
package adc_emu_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Widest sample and frame the assembly helper handles.
  localparam int MAX_W = 32;
  localparam int MAX_F = 256;

  function automatic int frame_bits(input int dw, input int lz, input int tz);
    return 2 * (lz + dw + tz);
  endfunction

  // {LEAD_Z 0, code_hi, TRAIL_Z 0, LEAD_Z 0, code_lo, TRAIL_Z 0}, right-aligned.
  function automatic logic [MAX_F-1:0] build_frame(input logic [MAX_W-1:0] code_hi,
                                                   input logic [MAX_W-1:0] code_lo,
                                                   input int dw, input int lz, input int tz);
    int half;
    half = lz + dw + tz;
    return (MAX_F'(code_hi) << (tz + half)) | (MAX_F'(code_lo) << tz);
  endfunction

endpackage

// File: rtl/adc_emu_edge_sync.sv
// adc_emu_edge_sync: STAGES-deep synchroniser (reset high) with registered falling/rising edge pulses
module adc_emu_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_fall,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_fall;
  logic              r_rise;

  // Shift the pin through the chain and compare the last two synchronised samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_fall <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_fall <= r_prev & ~r_sync[STAGES-1];
      r_rise <= ~r_prev & r_sync[STAGES-1];
    end
  end

  assign o_fall = r_fall;
  assign o_rise = r_rise;

endmodule

// File: rtl/adc_serial_emu.sv
// adc_serial_emu: AD7265-class dual-output serial ADC emulator; define ADC_EMU_TESTPAT_EN to add the testpat_sel counter pattern
module adc_serial_emu
  import adc_emu_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int N_CH        = 6,
  parameter int ADDR_W      = 3,
  parameter int LEAD_Z      = 2,
  parameter int TRAIL_Z     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef ADC_EMU_TESTPAT_EN
  input  logic                     testpat_sel,
`endif
  input  logic [N_CH*DATA_W-1:0]   din_a,
  input  logic [N_CH*DATA_W-1:0]   din_b,
  input  logic                     adc_sclk,
  input  logic                     ncs,
  input  logic                     rng,
  input  logic                     sgl,
  input  logic [ADDR_W-1:0]        adc_addr,
  output logic                     douta,
  output logic                     doutb,
  output logic                     dout_oe,
  output logic                     rng_latched,
  output logic [15:0]              conv_count,
  output logic                     frame_err,
  output logic                     addr_err
);

  localparam int FB = frame_bits(DATA_W, LEAD_Z, TRAIL_Z);
  localparam int CW = $clog2(FB + 1);
  localparam logic [ADDR_W:0] NCH = (ADDR_W + 1)'(N_CH);

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [FB-1:0]       r_frame_a, r_frame_b;
  logic                r_rng, r_frame_err, r_addr_err;
  logic [15:0]         r_conv;
  logic                w_sclk_fall, w_unused_sclk_rise, w_ncs_fall, w_ncs_rise;
  logic                w_load, w_shift, w_done, w_abort;
  logic                w_valid;
  logic [ADDR_W-1:0]   w_idx;
  logic [DATA_W-1:0]   w_src_a, w_src_b, w_code_a, w_code_b;
  logic [FB-1:0]       w_frame_a, w_frame_b;

  adc_emu_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (adc_sclk),
    .o_fall (w_sclk_fall),
    .o_rise (w_unused_sclk_rise)
  );

  adc_emu_edge_sync #(.STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (ncs),
    .o_fall (w_ncs_fall),
    .o_rise (w_ncs_rise)
  );

  // Select the addressed channel, apply sgl coding and zero out-of-range addresses, then assemble both frames.
  always_comb begin
    w_valid  = {1'b0, adc_addr} < NCH;
    w_idx    = w_valid ? adc_addr : '0;
`ifdef ADC_EMU_TESTPAT_EN
    w_src_a  = testpat_sel ? DATA_W'(r_conv) : din_a[DATA_W*int'(w_idx) +: DATA_W];
    w_src_b  = testpat_sel ? ~DATA_W'(r_conv) : din_b[DATA_W*int'(w_idx) +: DATA_W];
`else
    w_src_a  = din_a[DATA_W*int'(w_idx) +: DATA_W];
    w_src_b  = din_b[DATA_W*int'(w_idx) +: DATA_W];
`endif
    w_code_a = w_valid ? w_src_a ^ {~sgl, {(DATA_W-1){1'b0}}} : '0;
    w_code_b = w_valid ? w_src_b ^ {~sgl, {(DATA_W-1){1'b0}}} : '0;
    w_frame_a = FB'(build_frame(MAX_W'(w_code_a), MAX_W'(w_code_b), DATA_W, LEAD_Z, TRAIL_Z));
    w_frame_b = FB'(build_frame(MAX_W'(w_code_b), MAX_W'(w_code_a), DATA_W, LEAD_Z, TRAIL_Z));
  end

  // Next-state logic: capture beats a coincident sclk edge, ncs rise beats a coincident sclk edge.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = w_ncs_fall;
        w_next = w_ncs_fall ? SHIFT : IDLE;
      end
      SHIFT: begin
        w_abort = w_ncs_rise;
        w_shift = ~w_ncs_rise & w_sclk_fall;
        w_done  = w_shift & (r_cnt == CW'(1));
        w_next  = w_abort ? IDLE : (w_done ? DONE : SHIFT);
      end
      DONE:    w_next = w_ncs_rise ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Frame shifters, bit counter, frame counter and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_frame_a   <= '0;
      r_frame_b   <= '0;
      r_rng       <= 1'b0;
      r_conv      <= '0;
      r_frame_err <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      r_addr_err  <= w_load & ~w_valid;
      if (w_load) begin
        r_frame_a <= w_frame_a;
        r_frame_b <= w_frame_b;
        r_cnt     <= CW'(FB);
        r_rng     <= rng;
      end else if (w_shift) begin
        r_frame_a <= {r_frame_a[FB-2:0], 1'b0};
        r_frame_b <= {r_frame_b[FB-2:0], 1'b0};
        r_cnt     <= r_cnt - CW'(1);
      end
      if (w_done) r_conv <= r_conv + 16'd1;
    end
  end

  assign dout_oe     = (r_state == SHIFT);
  assign douta       = dout_oe & r_frame_a[FB-1];
  assign doutb       = dout_oe & r_frame_b[FB-1];
  assign rng_latched = r_rng;
  assign conv_count  = r_conv;
  assign frame_err   = r_frame_err;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_adc_serial_emu.sv
// tb_adc_serial_emu: scoreboard bench for adc_serial_emu (default build plus a 16-bit, 8-channel, no-padding build)
module tb_adc_serial_emu;

  localparam int DW0 = 12, NC0 = 6, LZ0 = 2, TZ0 = 2;
  localparam int DW1 = 16, NC1 = 8, LZ1 = 0, TZ1 = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] conv;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b1, ncs = 1'b1, rng = 1'b0, sgl = 1'b1, tp = 1'b0;
  logic [2:0] addr = '0;
  logic [NC0*DW0-1:0] da0 = '0, db0 = '0;
  logic [NC1*DW1-1:0] da1 = '0, db1 = '0;
  logic [1:0] oe, qa, qb, rngl, ferr, aerr;
  logic [15:0] conv0, conv1;

  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int n_ferr = 0, n_aerr = 0, m_ferr = 0, m_aerr = 0;
  logic [15:0] conv_m = '0;

  always #5 clk = ~clk;

  adc_serial_emu u0 (
`ifdef ADC_EMU_TESTPAT_EN
    .testpat_sel (tp),
`endif
    .clk (clk), .rst_n (rst_n), .din_a (da0), .din_b (db0), .adc_sclk (sclk), .ncs (ncs),
    .rng (rng), .sgl (sgl), .adc_addr (addr), .douta (qa[0]), .doutb (qb[0]), .dout_oe (oe[0]),
    .rng_latched (rngl[0]), .conv_count (conv0), .frame_err (ferr[0]), .addr_err (aerr[0])
  );

  adc_serial_emu #(.DATA_W(DW1), .N_CH(NC1), .ADDR_W(3), .LEAD_Z(LZ1), .TRAIL_Z(TZ1)) u1 (
`ifdef ADC_EMU_TESTPAT_EN
    .testpat_sel (tp),
`endif
    .clk (clk), .rst_n (rst_n), .din_a (da1), .din_b (db1), .adc_sclk (sclk), .ncs (ncs),
    .rng (rng), .sgl (sgl), .adc_addr (addr), .douta (qa[1]), .doutb (qb[1]), .dout_oe (oe[1]),
    .rng_latched (rngl[1]), .conv_count (conv1), .frame_err (ferr[1]), .addr_err (aerr[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Sample code from the ADC rules: channel pick, optional test pattern, MSB flip for differential, zero on bad address.
  function automatic logic [31:0] mcode(input logic [127:0] d, input int dw, input int nch, input int a,
                                        input bit s, input bit t, input bit inv, input logic [15:0] cc);
    logic [31:0] m, c;
    m = (32'd1 << dw) - 32'd1;
    c = t ? ((inv ? ~{16'h0, cc} : {16'h0, cc}) & m) : (32'(d >> (a * dw)) & m);
    if (!s) c = c ^ (32'd1 << (dw - 1));
    return (a < nch) ? c : 32'd0;
  endfunction

  function automatic logic [31:0] mframe(input logic [31:0] hi, input logic [31:0] lo,
                                         input int dw, input int lz, input int tz);
    return (hi << (tz + lz + dw + tz)) | (lo << tz);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    for (int k = 0; k < NC0; k++) begin
      da0[k*DW0 +: DW0] = DW0'($urandom);
      db0[k*DW0 +: DW0] = DW0'($urandom);
    end
    for (int k = 0; k < NC1; k++) begin
      da1[k*DW1 +: DW1] = DW1'($urandom);
      db1[k*DW1 +: DW1] = DW1'($urandom);
    end
    addr = 3'($urandom);
    sgl  = 1'($urandom);
    rng  = 1'($urandom);
  endtask

  // One ncs-framed transfer of nb sclk pulses; optionally reset mid-frame instead of raising ncs.
  task automatic run_frame(input int nb, input bit rst_mid);
    exp_t e0, e1;
    logic [31:0] a0, b0, a1, b1;
    a0 = mcode(128'(da0), DW0, NC0, int'(addr), sgl, tp, 1'b0, conv_m);
    b0 = mcode(128'(db0), DW0, NC0, int'(addr), sgl, tp, 1'b1, conv_m);
    a1 = mcode(da1, DW1, NC1, int'(addr), sgl, tp, 1'b0, conv_m);
    b1 = mcode(db1, DW1, NC1, int'(addr), sgl, tp, 1'b1, conv_m);
    e0 = '{a: mframe(a0, b0, DW0, LZ0, TZ0), b: mframe(b0, a0, DW0, LZ0, TZ0), conv: conv_m + 16'd1};
    e1 = '{a: mframe(a1, b1, DW1, LZ1, TZ1), b: mframe(b1, a1, DW1, LZ1, TZ1), conv: conv_m + 16'd1};
    if (int'(addr) >= NC0) m_aerr++;
    if (nb == 32 && !rst_mid) begin
      q0.push_back(e0);
      q1.push_back(e1);
      conv_m = conv_m + 16'd1;
    end
    tick(1);
    ncs = 1'b0;
    tick(8);
    for (int i = 0; i < nb; i++) begin
      sclk = 1'b0;
      tick(6);
      sclk = 1'b1;
      tick(6);
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      chk("rst_oe", 64'(oe), 64'd0);
      chk("rst_dout", 64'({qa, qb}), 64'd0);
      chk("rst_conv", 64'({conv0, conv1}), 64'd0);
      chk("rst_flags", 64'({rngl, ferr, aerr}), 64'd0);
      ncs = 1'b1;
      tick(2);
      rst_n = 1'b1;
      conv_m = '0;
      tick(4);
    end else begin
      ncs = 1'b1;
      tick(4);
      chk("oe_after_ncs", 64'(oe), 64'd0);
      chk("frame_err_now", 64'(ferr), (nb < 32) ? 64'd3 : 64'd0);
      if (nb < 32) m_ferr++;
      tick(4);
    end
    chk("conv0", 64'(conv0), 64'(conv_m));
    chk("conv1", 64'(conv1), 64'(conv_m));
    chk("rng_latched", 64'(rngl), rst_mid ? 64'd0 : {62'd0, rng, rng});
    chk("frame_err_cnt", 64'(n_ferr), 64'(m_ferr));
    chk("addr_err_cnt", 64'(n_aerr), 64'(m_aerr));
  endtask

  // Monitor: deserialise each side on sclk falls while enabled, score complete frames when the enable drops.
  logic sclk_q = 1'b1;
  int mc[2] = '{0, 0};
  logic [31:0] ma[2], mb[2];
  bit pend[2] = '{0, 0};

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (sclk_q && !sclk && oe[u] && !pend[u]) begin
        ma[u] = {ma[u][30:0], qa[u]};
        mb[u] = {mb[u][30:0], qb[u]};
        mc[u]++;
        if (mc[u] == 32) pend[u] = 1'b1;
      end
      if (!oe[u]) begin
        if (pend[u]) begin
          exp_t e;
          if ((u == 0 ? q0.size() : q1.size()) == 0) begin
            chk("scoreboard_underflow", 64'(u + 1), 64'd0);
          end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk(u == 0 ? "frame_a0" : "frame_a1", 64'(ma[u]), 64'(e.a));
            chk(u == 0 ? "frame_b0" : "frame_b1", 64'(mb[u]), 64'(e.b));
            chk(u == 0 ? "frame_conv0" : "frame_conv1", 64'(u == 0 ? conv0 : conv1), 64'(e.conv));
          end
          pend[u] = 1'b0;
        end
        mc[u] = 0;
      end
    end
    sclk_q = sclk;
    if (ferr[0]) n_ferr++;
    if (aerr[0]) n_aerr++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("reset_oe", 64'(oe), 64'd0);
    chk("reset_dout", 64'({qa, qb}), 64'd0);
    chk("reset_conv", 64'({conv0, conv1}), 64'd0);
    chk("reset_flags", 64'({rngl, ferr, aerr}), 64'd0);
    rst_n = 1'b1;
    tick(4);
    rand_in();
    addr = 3'd2;
    sgl  = 1'b1;
    da0[2*DW0 +: DW0] = 12'hABC;
    db0[2*DW0 +: DW0] = 12'h123;
    run_frame(32, 1'b0);
    rand_in();
    addr = 3'd0;
    sgl  = 1'b0;
    da0[0 +: DW0] = '0;
    run_frame(32, 1'b0);
    rand_in();
    run_frame(10, 1'b0);
    rand_in();
    addr = 3'd7;
    run_frame(32, 1'b0);
    rand_in();
    run_frame(16, 1'b1);
    rand_in();
    run_frame(32, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rand_in();
      run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32, 1'b0);
    end
    tick(4);
    chk("leftover", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
